// File: rtl/fs_hs_pkg.sv
// Shared definitions for the fs_hs registered ripple-borrow subtractor.
// Holds the default width and the half-subtractor cell equations.
package fs_hs_pkg;

    localparam int FS_HS_DEFAULT_WIDTH = 1;

    function automatic logic hs_diff(input logic x, input logic y);
        return x ^ y;
    endfunction

    function automatic logic hs_borrow(input logic x, input logic y);
        return ~x & y;
    endfunction

endpackage

// File: rtl/fs_hs_half_sub.sv
// One-bit half subtractor: d = x - y (mod 2), bo = borrow out.
module fs_hs_half_sub
    import fs_hs_pkg::*;
(
    input  logic x,
    input  logic y,
    output logic d,
    output logic bo
);

    assign d  = hs_diff(x, y);
    assign bo = hs_borrow(x, y);

endmodule

// File: rtl/fs_hs.sv
// Registered ripple-borrow subtractor: {bor, sub} = a - b - bin, one-cycle latency.
// Optional registered zero flag on the difference when FS_HS_ZERO_FLAG_EN is defined.
module fs_hs
    import fs_hs_pkg::*;
#(
    parameter int WIDTH = FS_HS_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic [WIDTH-1:0] sub,
    output logic             bor,
    output logic             out_valid
`ifdef FS_HS_ZERO_FLAG_EN
    ,
    output logic             zero
`endif
);

    typedef struct packed {
        logic             bor;
        logic [WIDTH-1:0] sub;
    } fs_hs_res_t;

    logic [WIDTH:0]   chain;
    logic [WIDTH-1:0] d1;
    logic [WIDTH-1:0] b1;
    logic [WIDTH-1:0] b2;
    logic [WIDTH-1:0] diff;

    fs_hs_res_t res_next;
    fs_hs_res_t res_reg;
    logic       valid_reg;

    assign chain[0] = bin;

    // Each bit: HS1 on the operands, HS2 folds in the incoming borrow.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            fs_hs_half_sub u_hs1 (
                .x  (a[gi]),
                .y  (b[gi]),
                .d  (d1[gi]),
                .bo (b1[gi])
            );

            fs_hs_half_sub u_hs2 (
                .x  (d1[gi]),
                .y  (chain[gi]),
                .d  (diff[gi]),
                .bo (b2[gi])
            );

            assign chain[gi+1] = b1[gi] | b2[gi];
        end
    endgenerate

    assign res_next.sub = diff;
    assign res_next.bor = chain[WIDTH];

`ifdef FS_HS_ZERO_FLAG_EN
    logic zero_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            zero_reg <= 1'b0;
        end else if (in_valid) begin
            zero_reg <= (res_next.sub == '0);
        end
    end

    assign zero = zero_reg;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_reg   <= '0;
            valid_reg <= 1'b0;
        end else begin
            valid_reg <= in_valid;
            if (in_valid) begin
                res_reg <= res_next;
            end
        end
    end

    assign sub       = res_reg.sub;
    assign bor       = res_reg.bor;
    assign out_valid = valid_reg;

endmodule

// File: tb/tb_fs_hs.sv
// Self-checking bench for fs_hs at WIDTH=1, 8 and 13 against an arithmetic model.
module tb_fs_hs;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        iv1, bin1, bor1, ov1;
    logic [0:0]  a1, b1, sub1;
    logic        iv8, bin8, bor8, ov8;
    logic [7:0]  a8, b8, sub8;
    logic        iv13, bin13, bor13, ov13;
    logic [12:0] a13, b13, sub13;
`ifdef FS_HS_ZERO_FLAG_EN
    logic zero1, zero8, zero13;
`endif

    int pass_cnt = 0;
    int total_cnt = 0;

    fs_hs #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(iv1), .a(a1), .b(b1), .bin(bin1),
        .sub(sub1), .bor(bor1), .out_valid(ov1)
`ifdef FS_HS_ZERO_FLAG_EN
        , .zero(zero1)
`endif
    );

    fs_hs #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .a(a8), .b(b8), .bin(bin8),
        .sub(sub8), .bor(bor8), .out_valid(ov8)
`ifdef FS_HS_ZERO_FLAG_EN
        , .zero(zero8)
`endif
    );

    fs_hs #(.WIDTH(13)) dut13 (
        .clk(clk), .rst(rst), .in_valid(iv13), .a(a13), .b(b13), .bin(bin13),
        .sub(sub13), .bor(bor13), .out_valid(ov13)
`ifdef FS_HS_ZERO_FLAG_EN
        , .zero(zero13)
`endif
    );

    // Reference: full-precision signed difference, then split into wrap and sign.
    function automatic longint ref_diff(int w, longint x, longint y, bit c);
        longint d;
        d = x - y - longint'(c);
        return d & ((longint'(1) << w) - 1);
    endfunction

    function automatic bit ref_bor(longint x, longint y, bit c);
        return (x < y + longint'(c));
    endfunction

    task automatic test_reset();
        iv1 = 1'b1; a1 = 1'b1; b1 = 1'b0; bin1 = 1'b0;
        iv8 = 1'b1; a8 = 8'h3C; b8 = 8'hC3; bin8 = 1'b1;
        iv13 = 1'b1; a13 = 13'h0123; b13 = 13'h1FFF; bin13 = 1'b0;
        #2 rst = 1'b1;
        #1;
        total_cnt++;
        if ({sub8, bor8, ov8} !== 10'b0) $display("FAIL reset_async8 got=%h req=0", {sub8, bor8, ov8});
        else pass_cnt++;
        repeat (2) @(posedge clk);
        #1;
        total_cnt++;
        if ({sub1, bor1, ov1, sub13, bor13, ov13} !== 18'b0)
            $display("FAIL reset_hold got=%h req=0", {sub1, bor1, ov1, sub13, bor13, ov13});
        else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
        iv1 = 1'b0; iv8 = 1'b0; iv13 = 1'b0;
        @(posedge clk); #1;
        total_cnt++;
        if ({sub8, bor8, ov8} !== 10'b0) $display("FAIL reset_release got=%h req=0", {sub8, bor8, ov8});
        else pass_cnt++;
        $display("test_reset done");
    endtask

    task automatic test_truth_table();
        logic [2:0] stim [8] = '{3'b000, 3'b010, 3'b110, 3'b100, 3'b001, 3'b011, 3'b111, 3'b101};
        logic [1:0] expv [8] = '{2'b00, 2'b11, 2'b00, 2'b10, 2'b11, 2'b01, 2'b11, 2'b00};
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            iv1 = 1'b1; a1 = stim[i][2]; b1 = stim[i][1]; bin1 = stim[i][0];
            @(posedge clk); #1;
            total_cnt++;
            if ({sub1, bor1, ov1} !== {expv[i], 1'b1})
                $display("FAIL truth_%0d abc=%b got sub=%b bor=%b ov=%b req sub=%b bor=%b ov=1",
                         i, stim[i], sub1, bor1, ov1, expv[i][1], expv[i][0]);
            else pass_cnt++;
            $display("truth a=%b b=%b bin=%b -> sub=%b bor=%b", a1, b1, bin1, sub1, bor1);
        end
    endtask

    task automatic test_directed();
        logic [16:0] vec [4] = '{{8'h05, 8'h07, 1'b0}, {8'h80, 8'h01, 1'b1},
                                 {8'h00, 8'h00, 1'b1}, {8'hA5, 8'hA5, 1'b0}};
        logic [8:0]  expv [4] = '{{8'hFE, 1'b1}, {8'h7E, 1'b0}, {8'hFF, 1'b1}, {8'h00, 1'b0}};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            iv8 = 1'b1; a8 = vec[i][16:9]; b8 = vec[i][8:1]; bin8 = vec[i][0];
            @(posedge clk); #1;
            total_cnt++;
            if ({sub8, bor8, ov8} !== {expv[i], 1'b1})
                $display("FAIL directed_%0d got sub=%h bor=%b ov=%b req sub=%h bor=%b ov=1",
                         i, sub8, bor8, ov8, expv[i][8:1], expv[i][0]);
            else pass_cnt++;
`ifdef FS_HS_ZERO_FLAG_EN
            total_cnt++;
            if (zero8 !== (expv[i][8:1] == 8'h00))
                $display("FAIL zero_%0d got=%b req=%b", i, zero8, (expv[i][8:1] == 8'h00));
            else pass_cnt++;
`endif
            $display("directed a=%h b=%h bin=%b -> sub=%h bor=%b", a8, b8, bin8, sub8, bor8);
        end
    endtask

    task automatic test_hold();
        logic [7:0] exp_sub;
        logic       exp_bor;
        @(negedge clk);
        iv8 = 1'b1; a8 = 8'h12; b8 = 8'h34; bin8 = 1'b1;
        exp_sub = 8'(ref_diff(8, 64'h12, 64'h34, 1'b1));
        exp_bor = ref_bor(64'h12, 64'h34, 1'b1);
        @(posedge clk); #1;
        total_cnt++;
        if ({sub8, bor8} !== {exp_sub, exp_bor})
            $display("FAIL hold_capture got %h/%b req %h/%b", sub8, bor8, exp_sub, exp_bor);
        else pass_cnt++;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            iv8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
            @(posedge clk); #1;
            total_cnt++;
            if ({sub8, bor8, ov8} !== {exp_sub, exp_bor, 1'b0})
                $display("FAIL hold_%0d got sub=%h bor=%b ov=%b req sub=%h bor=%b ov=0",
                         i, sub8, bor8, ov8, exp_sub, exp_bor);
            else pass_cnt++;
            $display("hold cycle %0d sub=%h bor=%b ov=%b", i, sub8, bor8, ov8);
        end
    endtask

    task automatic test_async_reset();
        logic [7:0] exp_sub;
        logic       exp_bor;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            iv8 = 1'b1; a8 = 8'($urandom); b8 = 8'($urandom) | 8'h01; bin8 = 1'b1;
        end
        @(negedge clk);
        a8 = 8'h01; b8 = 8'hF0; bin8 = 1'b0;
        #1 rst = 1'b1;
        #1;
        total_cnt++;
        if ({sub8, bor8, ov8} !== 10'b0)
            $display("FAIL async_reset got sub=%h bor=%b ov=%b req 0/0/0", sub8, bor8, ov8);
        else pass_cnt++;
        #1 rst = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
        exp_sub = 8'(ref_diff(8, longint'(a8), longint'(b8), bin8));
        exp_bor = ref_bor(longint'(a8), longint'(b8), bin8);
        @(posedge clk); #1;
        total_cnt++;
        if ({sub8, bor8, ov8} !== {exp_sub, exp_bor, 1'b1})
            $display("FAIL async_first got sub=%h bor=%b ov=%b req sub=%h bor=%b ov=1",
                     sub8, bor8, ov8, exp_sub, exp_bor);
        else pass_cnt++;
        $display("async reset release -> sub=%h bor=%b", sub8, bor8);
    endtask

    task automatic test_random();
        logic [0:0]  e_s1;  logic e_b1;
        logic [7:0]  e_s8;  logic e_b8;
        logic [12:0] e_s13; logic e_b13;
        int errs = 0;
        for (int i = 0; i < 10000; i++) begin
            @(negedge clk);
            iv1 = 1'b1; a1 = 1'($urandom); b1 = 1'($urandom); bin1 = 1'($urandom);
            iv8 = 1'b1; a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
            iv13 = 1'b1; a13 = 13'($urandom); b13 = 13'($urandom); bin13 = 1'($urandom);
            if (i % 97 == 5) b13 = a13;
            e_s1  = 1'(ref_diff(1, longint'(a1), longint'(b1), bin1));
            e_b1  = ref_bor(longint'(a1), longint'(b1), bin1);
            e_s8  = 8'(ref_diff(8, longint'(a8), longint'(b8), bin8));
            e_b8  = ref_bor(longint'(a8), longint'(b8), bin8);
            e_s13 = 13'(ref_diff(13, longint'(a13), longint'(b13), bin13));
            e_b13 = ref_bor(longint'(a13), longint'(b13), bin13);
            @(posedge clk); #1;
            total_cnt++;
            if ({sub1, bor1, ov1} !== {e_s1, e_b1, 1'b1}) begin
                errs++;
                if (errs < 20) $display("FAIL rand_w1 #%0d got %b/%b/%b req %b/%b/1", i, sub1, bor1, ov1, e_s1, e_b1);
            end else pass_cnt++;
            total_cnt++;
            if ({sub8, bor8, ov8} !== {e_s8, e_b8, 1'b1}) begin
                errs++;
                if (errs < 20) $display("FAIL rand_w8 #%0d got %h/%b/%b req %h/%b/1", i, sub8, bor8, ov8, e_s8, e_b8);
            end else pass_cnt++;
            total_cnt++;
            if ({sub13, bor13, ov13} !== {e_s13, e_b13, 1'b1}) begin
                errs++;
                if (errs < 20) $display("FAIL rand_w13 #%0d got %h/%b/%b req %h/%b/1", i, sub13, bor13, ov13, e_s13, e_b13);
            end else pass_cnt++;
`ifdef FS_HS_ZERO_FLAG_EN
            total_cnt++;
            if (zero13 !== (e_s13 == 13'd0)) begin
                errs++;
                if (errs < 20) $display("FAIL rand_zero13 #%0d got %b req %b", i, zero13, (e_s13 == 13'd0));
            end else pass_cnt++;
`endif
            if (i % 1000 == 0)
                $display("random #%0d w13 a=%h b=%h bin=%b -> sub=%h bor=%b", i, a13, b13, bin13, sub13, bor13);
        end
    endtask

    initial begin
        iv1 = 1'b0; a1 = '0; b1 = '0; bin1 = 1'b0;
        iv8 = 1'b0; a8 = '0; b8 = '0; bin8 = 1'b0;
        iv13 = 1'b0; a13 = '0; b13 = '0; bin13 = 1'b0;
        test_reset();
        test_truth_table();
        test_directed();
        test_hold();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/fs_hs.md
Name: fs_hs

Overview:
- Registered unsigned ripple-borrow subtractor: computes a − b − bin over WIDTH bits.
- Each bit cell is a full subtractor built from two half subtractors plus an OR of their borrows.
- Serves as the subtract primitive in datapaths that need a borrow-out, e.g. compare and decrement paths.
- One-cycle registered result with a valid strobe. At WIDTH=1 it is the classic 1-bit full subtractor.

Parameters:
- WIDTH, 1, operand and difference width in bits (≥1).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operands valid this cycle; result is captured on the next rising clk edge
- a  in  WIDTH  minuend (unsigned)
- b  in  WIDTH  subtrahend (unsigned)
- bin  in  1  borrow-in, LSB only
- sub  out  WIDTH  registered difference, (a − b − bin) mod 2^WIDTH
- bor  out  1  registered borrow-out; 1 iff a < b + bin (unsigned, full precision)
- out_valid  out  1  sub/bor were updated at the last edge

Behaviour:
- Half subtractor cell (x, y): d = x ^ y; bo = ~x & y.
- Full subtractor bit i:
  - HS1(a[i], b[i]) → d1, b1.
  - HS2(d1, c[i]) → sub_n[i], b2.
  - c[i+1] = b1 | b2.
  - c[0] = bin; bor_n = c[WIDTH].
- Datapath is purely combinational up to the output registers; no carry-lookahead is required.
- On rising clk with in_valid=1: sub <= sub_n, bor <= bor_n.
- On rising clk with in_valid=0: sub and bor hold their values.
- out_valid <= in_valid every edge, so latency is exactly 1 cycle and throughput is 1 result per cycle.
- Reset:
  - While rst=1, asynchronously: sub=0, bor=0, out_valid=0 (and zero=0 under the option).
  - Assertion mid-operation discards any in-flight result.
  - The first capture after deassertion is the first edge with rst=0 and in_valid=1.
- Wrap-around: a=0, b=0, bin=1 → sub = all ones, bor=1.
- Equal operands: a=b with bin=0 → sub=0, bor=0.
- X on inputs while in_valid=0 must not disturb the held outputs.

Optional Feature:
- Macro FS_HS_ZERO_FLAG_EN.
- Defined: adds output port zero (out, 1), registered with the same enable as sub. zero=1 iff sub_n == 0, whatever the borrow. Reset value 0.
- Undefined: port and logic are absent; all other behaviour is identical.

Decomposition:
- Package fs_hs_pkg:
  - localparam FS_HS_DEFAULT_WIDTH = 1.
  - typedef fs_hs_res_t: packed struct {logic bor; logic [WIDTH-1:0] sub} for the next-state bundle, sized via a parameterised function or a per-instance local typedef.
- Sub-module fs_hs_half_sub: 1-bit half subtractor (x, y → d, bo).
  - Instantiated twice per bit inside a generate loop.
  - The OR for the borrow chain stays in fs_hs.

Test Plan:
- WIDTH=1, in_valid=1, (a,b,bin) stepped 000,010,110,100,001,011,111,101 one per cycle → (sub,bor) one cycle later = (0,0),(1,1),(0,0),(1,0),(1,1),(0,1),(1,1),(0,0); out_valid=1 throughout.
- WIDTH=8: a=8'h05, b=8'h07, bin=0 → sub=8'hFE, bor=1. Then a=8'h80, b=8'h01, bin=1 → sub=8'h7E, bor=0.
- WIDTH=8: a=0, b=0, bin=1 → sub=8'hFF, bor=1. Then a=b=8'hA5, bin=0 → sub=0, bor=0 (zero=1 with FS_HS_ZERO_FLAG_EN).
- Hold: capture a result, then drop in_valid and toggle a/b/bin randomly for 5 cycles → sub and bor unchanged, out_valid=0 from the cycle after the drop.
- Async reset: with valid traffic flowing, pulse rst between clock edges → sub=0, bor=0, out_valid=0 immediately, without waiting for a clk edge. The first valid input after release appears 1 cycle later.
- Random: 10k random (a, b, bin) at WIDTH=1, 8 and 13 against the reference model {bor,sub} = {1'b0,a} − {1'b0,b} − bin → exact match.
